ws2812_receiver: RTL

Single-wire WS2812 (NRZ, GRB) receiver that decodes the LED data line back into 24-bit GRB control words. It is the far end of the LED transmit path: it classifies each high pulse by width, assembles bits MSB-first, and presents each completed 24-bit word with an index. End-of-frame is detected from the line-idle reset gap. Used for on-board loopback checking of the LED driver and as the input stage of a chained-module emulator.

---
 rtl/ws2812_pkg.sv | 17 +
 rtl/ws2812_receiver_sync2.sv | 21 ++
 rtl/ws2812_receiver.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: 100 MHz line timing, GRB word size and receiver states.
package ws2812_pkg;

  localparam int T0H      = 40;
  localparam int T1H      = 80;
  localparam int TBIT     = 125;
  localparam int TRESET   = 5000;
  localparam int GRB_BITS = 24;

  typedef enum logic [1:0] {
    ST_WAIT_GAP = 2'd0,
    ST_IDLE     = 2'd1,
    ST_HIGH     = 2'd2,
    ST_LOW      = 2'd3
  } rx_state_t;

endpackage

// File: rtl/ws2812_receiver_sync2.sv
// Two-flop synchronizer for the asynchronous data line; both stages reset to 0.
module ws2812_receiver_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ws2812_receiver.sv
// WS2812 NRZ receiver: classifies high-pulse widths, assembles MSB-first GRB words,
// and flags frame end on the line-idle reset gap.
module ws2812_receiver
  import ws2812_pkg::*;
#(
  parameter int CLKS_MIN_HIGH   = 15,
  parameter int CLKS_BIT_THRESH = 60,
  parameter int CLKS_MAX_HIGH   = 110,
  parameter int CLKS_RESET      = 5000,
  parameter int CNT_W           = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DataIn,
  output logic [23:0] Word,
  output logic        WordValid,
  output logic [3:0]  WordIndex,
  output logic        FrameDone,
  output logic        BitError
);

  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(CLKS_MIN_HIGH);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(CLKS_BIT_THRESH);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(CLKS_MAX_HIGH);
  localparam logic [CNT_W-1:0] RESET_C  = CNT_W'(CLKS_RESET);
  localparam logic [4:0]       LAST_BIT = 5'(GRB_BITS - 1);

  logic             ds;
  logic             ds_q;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt;

  rx_state_t state;
  rx_state_t state_nxt;

  logic        take_bit;
  logic        bit_val;
  logic        err;
  logic        frame_end;

  logic [22:0] shift_reg;
  logic [4:0]  bit_cnt;
  logic [3:0]  word_cnt;

  ws2812_receiver_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (DataIn),
    .q     (ds)
  );

  assign rise = ds & ~ds_q;
  assign fall = ~ds & ds_q;

  // The edge cycle is the first cycle of the new level, so the counter restarts
  // at 1: on a falling edge cnt equals the number of cycles ds was high.
  always_ff @(posedge clk) begin
    if (reset) begin
      ds_q <= 1'b0;
      cnt  <= '0;
    end else begin
      ds_q <= ds;
      if (rise || fall) begin
        cnt <= CNT_W'(1);
      end else if (cnt < RESET_C) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_WAIT_GAP;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    take_bit  = 1'b0;
    bit_val   = 1'b0;
    err       = 1'b0;
    frame_end = 1'b0;
    case (state)
      ST_WAIT_GAP: begin
        // A fall cycle still carries the high-time count, so it cannot arm.
        if (!ds && !fall && cnt >= RESET_C) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (rise) begin
          state_nxt = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (cnt > MAX_C) begin
          err = 1'b1;
        end else if (fall) begin
          if (cnt < MIN_C) begin
            err = 1'b1;
          end else begin
            take_bit  = 1'b1;
            bit_val   = (cnt >= THRESH_C);
            state_nxt = ST_LOW;
          end
        end
      end
      ST_LOW: begin
        if (cnt >= RESET_C) begin
          frame_end = 1'b1;
          state_nxt = rise ? ST_HIGH : ST_IDLE;
        end else if (rise) begin
          state_nxt = ST_HIGH;
        end
      end
      default: begin
        state_nxt = ST_WAIT_GAP;
      end
    endcase
    if (err) begin
      state_nxt = ST_WAIT_GAP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Word      <= '0;
      WordValid <= 1'b0;
      WordIndex <= '0;
      FrameDone <= 1'b0;
      BitError  <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
    end else begin
      WordValid <= 1'b0;
      FrameDone <= 1'b0;
      BitError  <= 1'b0;
      if (err) begin
        BitError  <= 1'b1;
        bit_cnt   <= '0;
        word_cnt  <= '0;
        WordIndex <= '0;
      end else if (frame_end) begin
        FrameDone <= 1'b1;
        BitError  <= (bit_cnt != 5'd0);
        bit_cnt   <= '0;
        word_cnt  <= '0;
      end else if (take_bit) begin
        if (bit_cnt == LAST_BIT) begin
          Word      <= {shift_reg, bit_val};
          WordValid <= 1'b1;
          WordIndex <= word_cnt;
          word_cnt  <= word_cnt + 4'd1;
          bit_cnt   <= '0;
        end else begin
          shift_reg <= {shift_reg[21:0], bit_val};
          bit_cnt   <= bit_cnt + 5'd1;
        end
      end
    end
  end

endmodule
